// File: rtl/z_chunk_adder_pkg.sv
// Shared types for the chunked adder: FSM state enum and a
// counter-width helper that never returns less than one bit.
package z_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/z_chunk_adder_if.sv
// Start/done request bundle for z_chunk_adder.
// master: start, sub, a, b, c_in out; sum, c_out, ovf, busy, done in.
interface z_chunk_adder_if #(
  parameter int N = 16
);
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, a, b, c_in,
    input  sum, c_out, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output sum, c_out, ovf, busy, done
  );
endinterface

// File: rtl/z_slice_add.sv
// Combinational W-bit ripple adder slice.
// a_i, b_i, c_i in; s_o sum, c_o carry-out, cm_o carry into the MSB.
module z_slice_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         cm_o
);
  logic [W:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < W; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i])
              | (a_i[i] & c[i])
              | (b_i[i] & c[i]);
    end
  end

  assign c_o  = c[W];
  assign cm_o = c[W-1];
endmodule

// File: rtl/z_chunk_adder.sv
// Multi-cycle N-bit add/sub, one CHUNK-bit slice per clock, LSB first.
// Ports: clk, rst (sync, active-high) and bus (z_chunk_adder_if.slave).
module z_chunk_adder
  import z_arith_pkg::*;
#(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  z_chunk_adder_if.slave   bus
);
  localparam int M  = N / CHUNK;
  localparam int KW = clog2_min1(M);
  localparam logic [N-1:0] MASK = N'({CHUNK{1'b1}});

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad
    $error("z_chunk_adder: N must be a positive multiple of CHUNK");
  end

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  part_q, part_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] sa, sb, ss;
  logic             sco, scm;
  logic [N-1:0]     part_m;
  logic             last;

  assign base = 32'(k_q) * 32'(CHUNK);
  assign sa   = CHUNK'(a_q >> base);
  assign sb   = CHUNK'(b_q >> base);
  assign last = (k_q == KW'(M - 1));

  z_slice_add #(.W(CHUNK)) u_slice (
    .a_i  (sa),
    .b_i  (sb),
    .c_i  (carry_q),
    .s_o  (ss),
    .c_o  (sco),
    .cm_o (scm)
  );

  // current slice merged into the partial sum
  assign part_m = (part_q & ~(MASK << base))
                | (N'(ss) << base);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.c_in ^ bus.sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        part_d  = part_m;
        carry_d = sco;
        if (last) begin
          sum_d   = part_m;
          cout_d  = sco;
          ovf_d   = scm ^ sco;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
endmodule

// File: doc/z_chunk_adder.md
# z_chunk_adder

Multi-cycle, parametrised two's-complement adder/subtractor that processes N-bit operands in CHUNK-bit slices, LSB slice first, one slice per clock. It trades latency for a short carry chain: per cycle the critical path is one CHUNK-bit ripple, independent of N. It sits in the arithmetic datapath wherever wide add/subtract results can tolerate multi-cycle latency under a start/done handshake.

## Interface
- N, 16, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 4, slice width per cycle; 1 ≤ CHUNK ≤ N.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+c_in, 1 = a−b−c_in (c_in acts as borrow-in).
- a  input  N  operand A, captured at accepted start.
- b  input  N  operand B, captured at accepted start.
- c_in  input  1  carry-in (add) / borrow-in (sub), captured at accepted start.
- sum  output  N  registered result.
- c_out  output  1  carry-out; in sub mode 1 = no borrow, 0 = borrow.
- ovf  output  1  signed overflow.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse marking a new result.

## Operation
- M = N/CHUNK slices. States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 → capture a, b_eff = sub ? ~b : b, carry = c_in ^ sub, slice index k=0; go RUN.
- RUN: busy=1. Each edge adds slice k of a, b_eff and carry via the slice adder, writes slice k of an internal partial-sum register, updates carry, increments k. When the edge processes slice M−1: load sum from the full partial result, c_out = final carry, ovf = (carry into bit N−1) ^ (carry out of bit N−1); go DONE.
- DONE: done=1, busy=0 for exactly one cycle. start=1 in DONE is accepted exactly as in IDLE (→RUN); otherwise → IDLE.
- start while busy=1 is ignored; captured operands are not disturbed by input changes after capture.
- sum, c_out, ovf change only on the completing edge; they hold the last result through IDLE and throughout a subsequent RUN.
- M=1 (CHUNK=N): single RUN cycle, same handshake.
- Arithmetic is modulo 2^N; no saturation.

## Timing
- Reset: state IDLE; sum=0, c_out=0, ovf=0, busy=0, done=0; k=0; partial-sum and carry cleared. Reset mid-RUN aborts the operation with no done pulse; rst dominates start in the same cycle.
- Start accepted at edge E0 → busy=1 from E0 through E(M−1) → sum/flags valid and done=1 after edge EM (done high for the cycle following EM).
- Throughput: one result per M+1 cycles with start held or re-asserted in DONE.

## Structure
- Shared package z_arith_pkg: state enum (IDLE, RUN, DONE) and a clog2 helper for the slice counter width (minimum 1 bit).
- One sub-module: z_slice_add, a combinational CHUNK-bit ripple adder with outputs sum slice, carry-out and carry into its MSB (used for ovf on the last slice).
- Parameter check: elaboration error if N mod CHUNK ≠ 0.

## Test plan
- N=16, CHUNK=4, add 0x1234+0x4321, c_in=0 → sum=0x5555, c_out=0, ovf=0; done exactly 4 edges after start edge, busy high 4 cycles.
- Add 0xFFFF+0x0001 → sum=0x0000, c_out=1, ovf=0; add 0x7FFF+0x0001 → sum=0x8000, c_out=0, ovf=1.
- Sub 0x0005−0x0007, c_in=0 → sum=0xFFFE, c_out=0, ovf=0; sub 0x8000−0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Start pulsed again mid-RUN with different operands → ignored; result of first operation only; inputs changed after capture have no effect.
- rst asserted in second RUN cycle → next cycle busy=0, done=0, sum=0; following start completes correctly with no stale done.
- start held high: back-to-back ops accepted in DONE cycle; sum holds prior result until the new completing edge; repeat with CHUNK=16 (M=1) and CHUNK=1 (M=16) for the latency rule.
